// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port, word-addressed data memory (port 0 = CPU, port 1 = DMA/debug).
// Define DMEM_ARB_ROUNDROBIN_EN for round-robin tie-breaking; the default build uses fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_LIMIT = 256,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [31:0]   addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [31:0]   addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [31:0]   mem_access_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  output logic          mem_read,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          grant;
  logic          in_range;

  assign in_range = (addr_q < 32'(ADDR_LIMIT));

  // grant = 0 selects port 0, 1 selects port 1; only meaningful when a request is present.
  always_comb begin
    grant = 1'b0;
`ifdef DMEM_ARB_ROUNDROBIN_EN
    if (req0 && req1) begin
      grant = ~last_q;
    end else begin
      grant = ~req0;
    end
`else
    grant = ~req0;
`endif
  end

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_SERVE;
          win_d   = grant;
          we_d    = grant ? we1    : we0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
        end
      end
      S_SERVE: begin
        state_d = S_ACK;
        // Out-of-range accesses clear the winner's read data; in-range reads capture the memory.
        if (!in_range) begin
          if (win_q) rdata1_d = '0;
          else       rdata0_d = '0;
        end else if (!we_q) begin
          if (win_q) rdata1_d = mem_read_data;
          else       rdata0_d = mem_read_data;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        last_d  = win_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Enables and acks decode straight from state_q, so an asynchronous reset kills them at once.
  assign mem_access_addr = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_write_en    = (state_q == S_SERVE) && we_q && in_range;
  assign mem_read        = (state_q == S_SERVE) && !we_q && in_range;

  assign ack0   = (state_q == S_ACK) && !win_q;
  assign ack1   = (state_q == S_ACK) && win_q;
  assign err0   = ack0 && !in_range;
  assign err1   = ack1 && !in_range;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected acks; a negedge monitor pops and compares.
module tb_dmem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [31:0]   addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [31:0]   mem_access_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en, mem_read;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LIMIT(256), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0            (req0),
    .we0             (we0),
    .addr0           (addr0),
    .wdata0          (wdata0),
    .ack0            (ack0),
    .rdata0          (rdata0),
    .err0            (err0),
    .req1            (req1),
    .we1             (we1),
    .addr1           (addr1),
    .wdata1          (wdata1),
    .ack1            (ack1),
    .rdata1          (rdata1),
    .err1            (err1),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .busy            (busy)
  );

  // Behavioural single-port memory, preloaded on the first clock (which falls inside reset).
  logic [31:0] mem [256];
  logic        mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[3]        <= 32'h3333_3333;
      mem[4]        <= 32'h4444_4444;
      mem[255]      <= 32'hFF00_FF00;
      mem_init_done <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_access_addr[7:0]] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_access_addr[7:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (!rst && (ack0 || ack1)) begin
      p = ack1 ? 1 : 0;
      check_eq("single_ack", 32'(ack0 && ack1), 32'h0);
      check_eq("sb_nonempty_on_ack", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("ack_port", 32'(p), 32'(e.port));
        check_eq(p ? "rdata1" : "rdata0", p ? rdata1 : rdata0, e.rdata);
        check_eq(p ? "err1" : "err0", 32'(p ? err1 : err0), 32'(e.err));
      end
    end
  end

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wd;
    end
  endtask

  task automatic do_reset();
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One isolated access from posedge+1 in IDLE: IDLE, SERVE, ACK negedges, then release.
  task automatic access(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic        inr;
    logic [31:0] other_rd;
    inr      = (addr < 32'd256);
    other_rd = p ? rdata0 : rdata1;
    drive_port(p, 1'b1, we, addr, wd);
    sb.push_back('{port: p, rdata: exp_rd, err: exp_err});
    for (int cnt = 1; cnt <= 3; cnt++) begin
      @(negedge clk);
      check_eq("busy", 32'(busy), 32'(cnt >= 2));
      check_eq("mem_write_en", 32'(mem_write_en), 32'((cnt == 2) && we && inr));
      check_eq("mem_read", 32'(mem_read), 32'((cnt == 2) && !we && inr));
      if (cnt == 2) check_eq("mem_access_addr", mem_access_addr, addr);
      if (cnt == 2 && we) check_eq("mem_write_data", mem_write_data, wd);
      check_eq(p ? "ack1_timing" : "ack0_timing", 32'(p ? ack1 : ack0), 32'(cnt == 3));
      check_eq("other_ack", 32'(p ? ack0 : ack1), 32'h0);
      check_eq("other_rdata", p ? rdata0 : rdata1, other_rd);
    end
    @(posedge clk); #1;
    drive_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int   ack_port [8];
  int   ack_cyc  [8];
  int   idle_btw [8];

  // Runs with requests already driven until n_acks acks; drops req0 after rel0_after acks (0 = hold).
  task automatic hold_run(input int n_acks, input int rel0_after);
    int   seen;
    int   idle;
    logic rel_pending;
    seen        = 0;
    idle        = 0;
    rel_pending = 1'b0;
    for (int cyc = 0; cyc < 60 && seen < n_acks; cyc++) begin
      @(negedge clk);
      if (!busy) idle++;
      if (ack0 || ack1) begin
        ack_port[seen] = ack1 ? 1 : 0;
        ack_cyc[seen]  = cyc;
        idle_btw[seen] = idle;
        idle           = 0;
        seen++;
        if (seen == rel0_after) rel_pending = 1'b1;
      end
      @(posedge clk); #1;
      if (rel_pending) begin
        req0        = 1'b0;
        rel_pending = 1'b0;
      end
    end
    check_eq("ack_count", 32'(seen), 32'(n_acks));
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_ack0", 32'(ack0), 32'h0);
    check_eq("rst_ack1", 32'(ack1), 32'h0);
    check_eq("rst_err0", 32'(err0), 32'h0);
    check_eq("rst_err1", 32'(err1), 32'h0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_wen", 32'(mem_write_en), 32'h0);
    check_eq("rst_rd", 32'(mem_read), 32'h0);
    check_eq("rst_addr", mem_access_addr, 32'h0);
    check_eq("rst_wdata", mem_write_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Port 0 write then read back
    access(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Simultaneous requests straight out of reset
    do_reset();
    drive_port(0, 1'b1, 1'b0, 32'd3, 32'h0);
    drive_port(1, 1'b1, 1'b0, 32'd4, 32'h0);
`ifdef DMEM_ARB_ROUNDROBIN_EN
    sb.push_back('{port: 0, rdata: 32'h3333_3333, err: 1'b0});
    sb.push_back('{port: 1, rdata: 32'h4444_4444, err: 1'b0});
    sb.push_back('{port: 0, rdata: 32'h3333_3333, err: 1'b0});
    sb.push_back('{port: 1, rdata: 32'h4444_4444, err: 1'b0});
    hold_run(4, 0);
`else
    sb.push_back('{port: 0, rdata: 32'h3333_3333, err: 1'b0});
    sb.push_back('{port: 0, rdata: 32'h3333_3333, err: 1'b0});
    sb.push_back('{port: 0, rdata: 32'h3333_3333, err: 1'b0});
    sb.push_back('{port: 1, rdata: 32'h4444_4444, err: 1'b0});
    hold_run(4, 3);
`endif
    check_eq("first_grant_port0", 32'(ack_port[0]), 32'h0);
    for (int i = 1; i < 4; i++) begin
      check_eq("contention_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end

    // Address limit boundary on port 1
    access(1, 1'b0, 32'd256, 32'h0, 32'h0, 1'b1);
    access(1, 1'b0, 32'd255, 32'h0, 32'hFF00_FF00, 1'b0);

    // Reset during SERVE drops the pending write and its ack
    drive_port(1, 1'b1, 1'b1, 32'd7, 32'h7777_7777);
    @(posedge clk); #2;
    check_eq("serve_wen_before_rst", 32'(mem_write_en), 32'h1);
    check_eq("serve_addr_before_rst", mem_access_addr, 32'd7);
    rst = 1'b1;
    #1;
    check_eq("rst_serve_wen", 32'(mem_write_en), 32'h0);
    check_eq("rst_serve_busy", 32'(busy), 32'h0);
    drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_ack1_after_abort", 32'(ack1), 32'h0);
    end
    @(posedge clk); #1;
    access(1, 1'b0, 32'd7, 32'h0, 32'h0, 1'b0);

    // Back-to-back on port 0 with req held across two accesses
    drive_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
    sb.push_back('{port: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    sb.push_back('{port: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    hold_run(2, 0);
    check_eq("b2b_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    check_eq("b2b_idle_cycles", 32'(idle_btw[1]), 32'd1);

    // Port 1 read while port 0 holds 0xDEADBEEF
    access(1, 1'b0, 32'd4, 32'h0, 32'h4444_4444, 1'b0);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
